// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM encoding and
// the helper that tells which operations run in the iterative datapath.
package alu_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD   = 4'd0;
  localparam op_t OP_SUB   = 4'd1;
  localparam op_t OP_AND   = 4'd2;
  localparam op_t OP_OR    = 4'd3;
  localparam op_t OP_XOR   = 4'd4;
  localparam op_t OP_SHR   = 4'd5;
  localparam op_t OP_SHL1A = 4'd6;
  localparam op_t OP_SHL1B = 4'd7;
  localparam op_t OP_MUL   = 4'd8;
  localparam op_t OP_SLT   = 4'd9;
  localparam op_t OP_UNDEF = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(input op_t op);
    return (op == OP_SHR) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: one-bit-per-cycle logical right shift and shift-add
// multiply. done/result/carry describe the step being taken this cycle.
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] W_EXT = (WIDTH + 1)'(WIDTH);

  logic              active_r;
  op_t               op_r;
  logic [CW-1:0]     cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]  mplr_r;

  logic [CW-1:0]      shr_n_s;
  logic [2*WIDTH-1:0] step_acc_s;

  // Shift distance saturates at WIDTH so large amounts still finish in WIDTH steps.
  always_comb begin
    if ({1'b0, b} >= W_EXT) begin
      shr_n_s = CW'(WIDTH);
    end else begin
      shr_n_s = CW'(b);
    end
  end

  always_comb begin
    step_acc_s = acc_r;
    result     = {WIDTH{1'b0}};
    carry      = 1'b0;
    if (op_r == OP_MUL) begin
      step_acc_s = acc_r + (mplr_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
      result     = step_acc_s[WIDTH-1:0];
      carry      = |step_acc_s[2*WIDTH-1:WIDTH];
    end else begin
      step_acc_s = {{WIDTH{1'b0}}, 1'b0, acc_r[WIDTH-1:1]};
      result     = step_acc_s[WIDTH-1:0];
      carry      = acc_r[0];
    end
  end

  assign done = active_r && (cnt_r == {CW{1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= 1'b0;
      op_r     <= OP_ADD;
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplr_r   <= {WIDTH{1'b0}};
    end else if (start) begin
      active_r <= 1'b1;
      op_r     <= op;
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplr_r   <= b;
      if (op == OP_MUL) begin
        cnt_r <= CW'(WIDTH - 1);
        acc_r <= {(2*WIDTH){1'b0}};
      end else begin
        cnt_r <= shr_n_s - {{(CW-1){1'b0}}, 1'b1};
        acc_r <= {{WIDTH{1'b0}}, a};
      end
    end else if (active_r) begin
      acc_r   <= step_acc_s;
      mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplr_r  <= {1'b0, mplr_r[WIDTH-1:1]};
      if (cnt_r == {CW{1'b0}}) begin
        active_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      active_r <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: FSM, valid/ready protocol and single-cycle ops;
// shifts by a variable amount and multiplies run in seq_alu_iter.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int OPCODE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in1,
  input  logic [WIDTH-1:0]  data_in2,
  input  logic [OPCODE-1:0] op_code,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  data_out,
  output logic              carry_out,
  output logic              zero_flag,
  output logic              slt_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_t           state_r;
  op_t              op_s;
  logic             op_hi_zero_s;
  logic             accept_s;
  logic             multi_s;
  logic             lt_s;
  logic [WIDTH-1:0] res_s;
  logic             cy_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_res_s;
  logic             iter_cy_s;

  // Any opcode beyond the 4-bit map is treated as undefined.
  assign op_hi_zero_s = ((op_code >> 4) == {OPCODE{1'b0}});
  assign op_s         = op_hi_zero_s ? op_code[3:0] : OP_UNDEF;

  assign in_ready = !rst && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign accept_s = in_valid && in_ready;
  assign lt_s     = (data_in1 < data_in2);
  assign multi_s  = is_multicycle(op_s) &&
                    !((op_s == OP_SHR) && (data_in2 == {WIDTH{1'b0}}));

  always_comb begin
    res_s = {WIDTH{1'b0}};
    cy_s  = 1'b0;
    case (op_s)
      OP_ADD:   {cy_s, res_s} = {1'b0, data_in1} + {1'b0, data_in2};
      OP_SUB:   begin res_s = data_in1 - data_in2; cy_s = lt_s; end
      OP_AND:   res_s = data_in1 & data_in2;
      OP_OR:    res_s = data_in1 | data_in2;
      OP_XOR:   res_s = data_in1 ^ data_in2;
      OP_SHR:   res_s = data_in1;
      OP_SHL1A: begin res_s = {data_in1[WIDTH-2:0], 1'b0}; cy_s = data_in1[WIDTH-1]; end
      OP_SHL1B: begin res_s = {data_in2[WIDTH-2:0], 1'b0}; cy_s = data_in2[WIDTH-1]; end
      OP_SLT:   res_s = {{(WIDTH-1){1'b0}}, lt_s};
      default:  begin res_s = {WIDTH{1'b0}}; cy_s = 1'b0; end
    endcase
  end

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept_s && multi_s),
    .op     (op_s),
    .a      (data_in1),
    .b      (data_in2),
    .done   (iter_done_s),
    .result (iter_res_s),
    .carry  (iter_cy_s)
  );

  // DONE with out_ready behaves like IDLE so a new op can launch without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      data_out  <= {WIDTH{1'b0}};
      carry_out <= 1'b0;
      zero_flag <= 1'b1;
      slt_flag  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            slt_flag <= lt_s;
            if (multi_s) begin
              state_r   <= EXEC;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              state_r   <= DONE;
              data_out  <= res_s;
              carry_out <= cy_s;
              zero_flag <= (res_s == {WIDTH{1'b0}});
              out_valid <= 1'b1;
            end
          end else if ((state_r == DONE) && out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        EXEC: begin
          if (iter_done_s) begin
            state_r   <= DONE;
            data_out  <= iter_res_s;
            carry_out <= iter_cy_s;
            zero_flag <= (iter_res_s == {WIDTH{1'b0}});
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
